// File: rtl/clk_div_multi_pkg.sv
// ============================================================================
// Module  : clk_div_multi_pkg
// Brief   : Shared constants and channel action encoding for clk_div_multi.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_multi_pkg;

  localparam int CNT_W_DEF   = 25;
  localparam int DIV_RST_DEF = 25000000;

  // Divisors for a 50 MHz board clock (period = 2*(div+1) cycles)
  localparam int DIV_1HZ     = 24999999;
  localparam int DIV_1KHZ    = 24999;
  localparam int DIV_100HZ   = 249999;

  typedef enum logic [1:0] {
    ACT_CLEAR = 2'd0,
    ACT_WRAP  = 2'd1,
    ACT_COUNT = 2'd2
  } chan_act_e;

  // Restart (sync_clr or disable) outranks the terminal-count wrap.
  function automatic chan_act_e chan_action(input logic en, input logic sync_clr,
                                            input logic term);
    if (sync_clr || !en) return ACT_CLEAR;
    else if (term)       return ACT_WRAP;
    else                 return ACT_COUNT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_multi_if.sv
// ============================================================================
// Module  : clk_div_multi_if
// Brief   : Control/divisor-write bus and divided outputs of clk_div_multi.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface clk_div_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 25,
  parameter int CH_W  = 2
);
  logic [NCH-1:0]   en;
  logic             sync_clr;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  modport master (
    output en, sync_clr, wr_en, wr_ch, wr_div,
    input  clk_out, tick
  );

  modport slave (
    input  en, sync_clr, wr_en, wr_ch, wr_div,
    output clk_out, tick
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_multi_chan.sv
// ============================================================================
// Module  : clk_div_multi_chan
// Brief   : One divider channel: counter, shadow/active divisor, toggle, tick.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_multi_chan
  import clk_div_multi_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             en,
  input  wire logic             sync_clr,
  input  wire logic             ld,
  input  wire logic [CNT_W-1:0] ld_val,
  output logic                  clk_out,
  output logic                  tick
);

  localparam logic [CNT_W-1:0] c_div_rst = CNT_W'(DIV_RST);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] w_reload;
  chan_act_e        w_act;

  always_comb begin
    // A write landing on a reload edge bypasses the shadow register.
    w_reload  = ld ? ld_val : shadow_q;
    w_act     = chan_action(en, sync_clr, cnt_q == active_q);
    shadow_d  = w_reload;
    cnt_d     = cnt_q;
    active_d  = active_q;
    clk_out_d = clk_out_q;
    tick_d    = tick_q;
    case (w_act)
      ACT_CLEAR: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        active_d  = w_reload;
      end
      ACT_WRAP: begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = 1'b1;
        active_d  = w_reload;
      end
      default: begin
        cnt_d     = cnt_q + 1'b1;
        tick_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      shadow_q  <= c_div_rst;
      active_q  <= c_div_rst;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
// Module  : clk_div_multi
// Brief   : NCH-channel programmable 50%-duty divider with per-channel ticks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int CH_W    = 2,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  wire logic      clk,
  input  wire logic      rst,
  clk_div_multi_if.slave bus
);

  // Indices at or beyond NCH (possible when NCH < 2**CH_W) select nothing.
  logic w_wr_ok;
  assign w_wr_ok = bus.wr_en && (int'(bus.wr_ch) < NCH);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic w_ld;
    assign w_ld = w_wr_ok && (bus.wr_ch == CH_W'(i));

    clk_div_multi_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en[i]),
      .sync_clr (bus.sync_clr),
      .ld       (w_ld),
      .ld_val   (bus.wr_div),
      .clk_out  (bus.clk_out[i]),
      .tick     (bus.tick[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
// Module  : tb_clk_div_multi
// Brief   : Directed bench for clk_div_multi (NCH=4 and NCH=3 builds, DIV_RST=3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_multi;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  clk_div_multi_if #(.NCH(4), .CNT_W(8), .CH_W(2)) bus4 ();
  clk_div_multi_if #(.NCH(3), .CNT_W(8), .CH_W(2)) bus3 ();

  clk_div_multi #(.NCH(4), .CNT_W(8), .CH_W(2), .DIV_RST(3)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  clk_div_multi #(.NCH(3), .CNT_W(8), .CH_W(2), .DIV_RST(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, returning on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus4.en = 4'hF; bus4.sync_clr = 1'b0; bus4.wr_en = 1'b0; bus4.wr_ch = '0; bus4.wr_div = '0;
    bus3.en = 3'h7; bus3.sync_clr = 1'b0; bus3.wr_en = 1'b0; bus3.wr_ch = '0; bus3.wr_div = '0;

    @(negedge clk);
    chk("rst_clk", bus4.clk_out, 4'h0);
    chk("rst_tick", bus4.tick, 4'h0);
    rst = 1'b1;

    cyc(3);  chk("e3_clk", bus4.clk_out, 4'h0);  chk("e3_tick", bus4.tick, 4'h0);
    cyc(1);  chk("e4_clk", bus4.clk_out, 4'hF);  chk("e4_tick", bus4.tick, 4'hF);
    cyc(1);  chk("e5_clk", bus4.clk_out, 4'hF);  chk("e5_tick", bus4.tick, 4'h0);
    cyc(3);  chk("e8_clk", bus4.clk_out, 4'h0);  chk("e8_tick", bus4.tick, 4'hF);
    cyc(4);  chk("e12_clk", bus4.clk_out, 4'hF); chk("e12_tick", bus4.tick, 4'hF);

    // Mid-period write of divisor 0 to channel 1
    cyc(2);
    bus4.wr_en = 1'b1; bus4.wr_ch = 2'd1; bus4.wr_div = 8'd0;
    cyc(1);
    bus4.wr_en = 1'b0;
    chk("wr1_hold_clk", bus4.clk_out, 4'hF); chk("wr1_hold_tick", bus4.tick, 4'h0);
    cyc(1);  chk("e16_clk", bus4.clk_out, 4'b0000); chk("e16_tick", bus4.tick, 4'b1111);
    cyc(1);  chk("e17_clk", bus4.clk_out, 4'b0010); chk("e17_tick", bus4.tick, 4'b0010);
    cyc(1);  chk("e18_clk", bus4.clk_out, 4'b0000); chk("e18_tick", bus4.tick, 4'b0010);
    cyc(2);  chk("e20_clk", bus4.clk_out, 4'b1101); chk("e20_tick", bus4.tick, 4'b1111);

    // Write divisor 9 to channel 2 on the same edge as sync_clr
    bus4.wr_en = 1'b1; bus4.wr_ch = 2'd2; bus4.wr_div = 8'd9; bus4.sync_clr = 1'b1;
    cyc(1);
    bus4.wr_en = 1'b0; bus4.sync_clr = 1'b0;
    chk("sclr_clk", bus4.clk_out, 4'b0000); chk("sclr_tick", bus4.tick, 4'b0000);
    cyc(4);  chk("e25_clk", bus4.clk_out, 4'b1001); chk("e25_tick", bus4.tick, 4'b1011);
    cyc(5);  chk("e30_clk", bus4.clk_out, 4'b0010); chk("e30_tick", bus4.tick, 4'b0010);
    cyc(1);  chk("e31_clk", bus4.clk_out, 4'b0100); chk("e31_tick", bus4.tick, 4'b0110);

    // Disable channel 3 for five cycles while its output is high
    cyc(2);
    chk("e33_ch3", {2'b00, bus4.clk_out[3], bus4.tick[3]}, 4'b0011);
    bus4.en = 4'b0111;
    cyc(1);  chk("dis1_ch3", {2'b00, bus4.clk_out[3], bus4.tick[3]}, 4'b0000);
    cyc(4);  chk("dis5_ch3", {2'b00, bus4.clk_out[3], bus4.tick[3]}, 4'b0000);
    bus4.en = 4'hF;
    cyc(3);
    chk("ren3_ch3", {2'b00, bus4.clk_out[3], bus4.tick[3]}, 4'b0000);
    chk("ren3_ch0", {3'b000, bus4.clk_out[0]}, 4'b0001);
    cyc(1);  chk("ren4_ch3", {2'b00, bus4.clk_out[3], bus4.tick[3]}, 4'b0011);

    // Asynchronous reset between clock edges
    #2 rst = 1'b0;
    #1;
    chk("arst_clk", bus4.clk_out, 4'h0);
    chk("arst_tick", bus4.tick, 4'h0);
    chk("arst3_clk", {1'b0, bus3.clk_out}, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    // Out-of-range write on the three-channel build
    bus3.wr_en = 1'b1; bus3.wr_ch = 2'd3; bus3.wr_div = 8'd0;
    cyc(1);
    bus3.wr_en = 1'b0;
    cyc(2);
    chk("post_e3_clk", bus4.clk_out, 4'h0);
    chk("n3_e3_clk", {1'b0, bus3.clk_out}, 4'h0);
    chk("n3_e3_tick", {1'b0, bus3.tick}, 4'h0);
    cyc(1);
    chk("post_e4_clk", bus4.clk_out, 4'hF);  chk("post_e4_tick", bus4.tick, 4'hF);
    chk("n3_e4_clk", {1'b0, bus3.clk_out}, 4'h7);
    chk("n3_e4_tick", {1'b0, bus3.tick}, 4'h7);
    cyc(1);
    chk("n3_e5_tick", {1'b0, bus3.tick}, 4'h0);
    cyc(3);
    chk("post_e8_clk", bus4.clk_out, 4'h0);
    chk("n3_e8_clk", {1'b0, bus3.clk_out}, 4'h0);
    chk("n3_e8_tick", {1'b0, bus3.tick}, 4'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
